branch_predictor: RTL and testbench

Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage RV32I pipeline. Fetch looks up the current fetch PC in the same cycle and gets a predicted next PC. Execute reports each resolved branch or jump back to the block, which trains the table and flags mispredictions so the pipeline can flush IF/ID and redirect. The block also keeps performance counters for resolved and mispredicted control transfers.

---
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// Fetch lookup and EX mispredict detection are combinational; training and counters are registered.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    output logic [31:0]      if_pred_pc_o,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_pc_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   branch_cnt_q, mispred_cnt_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic [31:0]      if_seq_pc, ex_seq_pc, actual_next;
    logic             pred_taken_unused;

    // Direction is already implied by the carried predicted PC.
    assign pred_taken_unused = ex_pred_taken_i;

    assign if_idx    = if_pc_i[IDX_W+1:2];
    assign if_tag    = if_pc_i[31:IDX_W+2];
    assign ex_idx    = ex_pc_i[IDX_W+1:2];
    assign ex_tag    = ex_pc_i[31:IDX_W+2];
    assign if_seq_pc = if_pc_i + 32'd4;
    assign ex_seq_pc = ex_pc_i + 32'd4;

    assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit          = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign if_pred_taken_o = if_hit && ctr_q[if_idx][CTR_W-1];
    assign if_pred_pc_o    = if_pred_taken_o ? target_q[if_idx] : if_seq_pc;

    assign actual_next   = ex_taken_i ? ex_target_i : ex_seq_pc;
    assign mispredict_o  = ex_valid_i && (ex_pred_pc_i != actual_next);
    assign redirect_pc_o = ex_valid_i ? actual_next : ex_seq_pc;

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    // Table training; flush overrides any same-cycle update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (ex_valid_i) begin
            if (ex_hit) begin
                if (ex_taken_i) begin
                    target_q[ex_idx] <= ex_target_i;
                    if (ctr_q[ex_idx] != CTR_MAX) ctr_q[ex_idx] <= ctr_q[ex_idx] + CTR_W'(1);
                end else if (ctr_q[ex_idx] != '0) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - CTR_W'(1);
                end
            end else if (ex_taken_i) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target_i;
                ctr_q[ex_idx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ex_valid_i)   branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
            if (mispredict_o) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_branch_predictor;
    localparam int unsigned NE = 64;

    logic        clk = 1'b0;
    logic        rst_i, flush_i;
    logic [31:0] if_pc_i, ex_pc_i, ex_target_i, ex_pred_pc_i;
    logic        ex_valid_i, ex_taken_i, ex_pred_taken_i;
    logic        if_pred_taken_o, mispredict_o;
    logic [31:0] if_pred_pc_o, redirect_pc_o, branch_cnt_o, mispred_cnt_o;

    logic        w_ex_valid;
    logic        w_pt, w_mis;
    logic [31:0] w_pp, w_redir;
    logic [3:0]  w_bcnt, w_mcnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .CTR_W(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .if_pc_i(if_pc_i),
        .if_pred_taken_o(if_pred_taken_o), .if_pred_pc_o(if_pred_pc_o),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_taken_i(ex_taken_i),
        .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_pc_i(ex_pred_pc_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o));

    // Narrow-counter instance used for the wrap-around check.
    branch_predictor #(.ENTRIES(2), .CTR_W(1), .CNT_W(4)) dut_w (
        .clk_i(clk), .rst_i(rst_i), .flush_i(1'b0), .if_pc_i(32'h100),
        .if_pred_taken_o(w_pt), .if_pred_pc_o(w_pp),
        .ex_valid_i(w_ex_valid), .ex_pc_i(32'h100), .ex_taken_i(1'b1),
        .ex_target_i(32'h40), .ex_pred_taken_i(1'b0), .ex_pred_pc_i(32'h0),
        .mispredict_o(w_mis), .redirect_pc_o(w_redir),
        .branch_cnt_o(w_bcnt), .mispred_cnt_o(w_mcnt));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays, index/tag by integer division.
    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];

    function automatic void m_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] npc);
        int unsigned i = (pc / 4) % NE;
        t   = m_valid[i] && (m_tag[i] == pc / (4 * NE)) && (m_ctr[i] >= 2);
        npc = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic fl, input logic ev, input logic [31:0] pc,
                                     input logic tk, input logic [31:0] tgt);
        int unsigned i = (pc / 4) % NE;
        bit hit = m_valid[i] && (m_tag[i] == pc / (4 * NE));
        if (fl) begin
            for (int k = 0; k < NE; k++) m_valid[k] = 0;
        end else if (ev) begin
            if (hit && tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = pc / (4 * NE); m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end
    endfunction

    function automatic logic [31:0] rpc();
        if ($urandom_range(0, 15) == 0) return $urandom & 32'hFFFF_FFFC;
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2));
    endfunction

    typedef struct {
        logic fl; logic [31:0] ifpc; logic ev; logic [31:0] epc; logic et;
        logic [31:0] etgt; logic [31:0] epp;
        logic xpt; logic [31:0] xpp; logic xmis; logic [31:0] xred;
    } vec_t;

    vec_t        vt [18];
    logic [31:0] bexp, mexp, p, actual;
    logic        t, xmis;

    task automatic drive(input logic fl, input logic [31:0] ifpc, input logic ev, input logic [31:0] epc,
                         input logic et, input logic [31:0] etgt, input logic [31:0] epp);
        flush_i = fl; if_pc_i = ifpc; ex_valid_i = ev; ex_pc_i = epc;
        ex_taken_i = et; ex_target_i = etgt; ex_pred_pc_i = epp; ex_pred_taken_i = 1'b0;
    endtask

    initial begin
        //         fl  if_pc         ev  ex_pc         tk  target      pred_pc    | pt  pred_pc      mis redirect
        vt[0]  = '{0, 32'h100,      1, 32'h100,      1, 32'h40,  32'h104,   0, 32'h104,      1, 32'h40};
        vt[1]  = '{0, 32'h100,      1, 32'h100,      1, 32'h40,  32'h40,    1, 32'h40,       0, 32'h40};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = '{0, 32'h100,      1, 32'h100,      0, 32'h999, 32'h40,    1, 32'h40,       1, 32'h104};
        vt[5]  = vt[4];
        vt[6]  = '{0, 32'h100,      0, 32'h10,       0, 32'h0,   32'h0,     0, 32'h104,      0, 32'h14};
        vt[7]  = '{0, 32'h200,      1, 32'h200,      1, 32'h80,  32'h204,   0, 32'h204,      1, 32'h80};
        vt[8]  = '{0, 32'h100,      0, 32'h0,        0, 32'h0,   32'h0,     0, 32'h104,      0, 32'h4};
        vt[9]  = '{0, 32'h200,      0, 32'h0,        0, 32'h0,   32'h0,     1, 32'h80,       0, 32'h4};
        vt[10] = '{0, 32'h104,      1, 32'h100,      1, 32'h40,  32'h104,   0, 32'h108,      1, 32'h40};
        vt[11] = '{0, 32'h100,      1, 32'h100,      1, 32'h60,  32'h40,    1, 32'h40,       1, 32'h60};
        vt[12] = '{0, 32'h100,      0, 32'h0,        0, 32'h0,   32'h0,     1, 32'h60,       0, 32'h4};
        vt[13] = '{1, 32'h100,      1, 32'h104,      1, 32'h300, 32'h108,   1, 32'h60,       1, 32'h300};
        vt[14] = '{0, 32'h100,      0, 32'h0,        0, 32'h0,   32'h0,     0, 32'h104,      0, 32'h4};
        vt[15] = '{0, 32'h104,      0, 32'h0,        0, 32'h0,   32'h0,     0, 32'h108,      0, 32'h4};
        vt[16] = '{0, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0,   32'h0,     0, 32'h0,        0, 32'h4};
        vt[17] = '{0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,  32'h0,     0, 32'h4,        0, 32'h0};

        // Reset: outputs immediately reflect an empty table; mispredict still follows inputs.
        rst_i = 1'b1; w_ex_valid = 1'b0;
        drive(0, 32'h100, 1, 32'h100, 1, 32'h40, 32'h104);
        #1;
        check("rst_pred_taken", 32'(if_pred_taken_o), 32'h0);
        check("rst_pred_pc", if_pred_pc_o, 32'h104);
        check("rst_branch_cnt", branch_cnt_o, 32'h0);
        check("rst_mispred_cnt", mispred_cnt_o, 32'h0);
        check("rst_mispredict", 32'(mispredict_o), 32'h1);
        check("rst_redirect", redirect_pc_o, 32'h40);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0;
        bexp = 0; mexp = 0;

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].ifpc, vt[i].ev, vt[i].epc, vt[i].et, vt[i].etgt, vt[i].epp);
            #1;
            check($sformatf("v%0d_pred_taken", i), 32'(if_pred_taken_o), 32'(vt[i].xpt));
            check($sformatf("v%0d_pred_pc", i), if_pred_pc_o, vt[i].xpp);
            check($sformatf("v%0d_mispredict", i), 32'(mispredict_o), 32'(vt[i].xmis));
            check($sformatf("v%0d_redirect", i), redirect_pc_o, vt[i].xred);
            @(posedge clk);
            bexp += 32'(vt[i].ev); mexp += 32'(vt[i].xmis);
            #1;
            check($sformatf("v%0d_branch_cnt", i), branch_cnt_o, bexp);
            check($sformatf("v%0d_mispred_cnt", i), mispred_cnt_o, mexp);
            @(negedge clk);
        end

        // Reset asserted while an update is pending: nothing of it may survive.
        drive(0, 32'h0, 1, 32'h400, 1, 32'h500, 32'h404);
        @(posedge clk); @(negedge clk);
        drive(0, 32'h400, 0, 32'h0, 0, 32'h0, 32'h0);
        #1 check("alloc_400_hit", if_pred_pc_o, 32'h500);
        @(negedge clk);
        drive(0, 32'h400, 1, 32'h400, 1, 32'h600, 32'h500);
        rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        drive(0, 32'h400, 0, 32'h0, 0, 32'h0, 32'h0);
        #1;
        check("rst_mid_pred_pc", if_pred_pc_o, 32'h404);
        check("rst_mid_branch_cnt", branch_cnt_o, 32'h0);
        check("rst_mid_mispred_cnt", mispred_cnt_o, 32'h0);

        // 4-bit counters wrap after 16 resolutions (each one mispredicted).
        for (int i = 0; i < 16; i++) begin
            w_ex_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 14) begin
                check("wrap_branch_cnt_max", 32'(w_bcnt), 32'hF);
                check("wrap_mispred_cnt_max", 32'(w_mcnt), 32'hF);
            end
            @(negedge clk);
        end
        w_ex_valid = 1'b0;
        check("wrap_branch_cnt_zero", 32'(w_bcnt), 32'h0);
        check("wrap_mispred_cnt_zero", 32'(w_mcnt), 32'h0);

        // Randomized traffic against the reference model.
        m_reset();
        rst_i = 1'b1; #1; rst_i = 1'b0;
        @(negedge clk);
        bexp = 0; mexp = 0;
        for (int n = 0; n < 400; n++) begin
            flush_i     = ($urandom_range(0, 29) == 0);
            if_pc_i     = rpc();
            ex_valid_i  = ($urandom_range(0, 3) != 0);
            ex_pc_i     = rpc();
            ex_taken_i  = 1'($urandom_range(0, 1));
            ex_target_i = 32'($urandom_range(0, 7) * 16);
            m_lookup(ex_pc_i, t, p);
            ex_pred_taken_i = t;
            ex_pred_pc_i    = ($urandom_range(0, 2) != 0) ? p : 32'($urandom_range(0, 7) * 16);
            #1;
            m_lookup(if_pc_i, t, p);
            actual = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
            xmis   = ex_valid_i && (ex_pred_pc_i != actual);
            check("rand_pred_taken", 32'(if_pred_taken_o), 32'(t));
            check("rand_pred_pc", if_pred_pc_o, p);
            check("rand_mispredict", 32'(mispredict_o), 32'(xmis));
            check("rand_redirect", redirect_pc_o, ex_valid_i ? actual : ex_pc_i + 32'd4);
            @(posedge clk);
            m_update(flush_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i);
            bexp += 32'(ex_valid_i); mexp += 32'(xmis);
            #1;
            check("rand_branch_cnt", branch_cnt_o, bexp);
            check("rand_mispred_cnt", mispred_cnt_o, mexp);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
